// File: rtl/hilo_seq_ctrl.sv
// HI/LO multi-cycle sequencer for the EX stage: MADD/MSUB accumulate and DIV/DIVU
// divider handshake, with flush, external stall and divide timeout handling.
`timescale 1ns/1ps
module hilo_seq_ctrl #(
  parameter int DIV_TIMEOUT = 40,
  parameter int CNT_W       = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] reg1_data_i,
  input  logic [31:0] reg2_data_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic        ex_stall_i,
  input  logic        flush_i,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        div_start_o,
  output logic        div_annul_o,
  output logic        div_signed_o,
  output logic [31:0] div_op1_o,
  output logic [31:0] div_op2_o,
  output logic        hilo_we_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        stallreq_o,
  output logic        timeout_o,
  output logic [1:0]  state_o
);

  localparam logic [7:0] ALU_MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] ALU_MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] ALU_MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] ALU_MSUBU_OP = 8'b1010_1011;
  localparam logic [7:0] ALU_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] ALU_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DIV_WAIT, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [63:0]       prod_q, prod_d;
  logic              sub_q, sub_d;
  logic [31:0]       op1_q, op1_d;
  logic [31:0]       op2_q, op2_d;
  logic              sgn_q, sgn_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic              is_madd, is_msub, is_smul, is_div;
  logic [63:0]       mul_s, mul_u, hilo_cur;
  logic [CNT_W-1:0]  cnt_inc;
  state_t            after_wb;
  logic              start_c, annul_c, we_c, stall_c;
  logic [63:0]       res_c;

  assign is_madd  = (aluop_i == ALU_MADD_OP) || (aluop_i == ALU_MADDU_OP) ||
                    (aluop_i == ALU_MSUB_OP) || (aluop_i == ALU_MSUBU_OP);
  assign is_msub  = (aluop_i == ALU_MSUB_OP) || (aluop_i == ALU_MSUBU_OP);
  assign is_smul  = (aluop_i == ALU_MADD_OP) || (aluop_i == ALU_MSUB_OP);
  assign is_div   = (aluop_i == ALU_DIV_OP) || (aluop_i == ALU_DIVU_OP);
  assign mul_s    = 64'($signed(reg1_data_i)) * 64'($signed(reg2_data_i));
  assign mul_u    = {32'd0, reg1_data_i} * {32'd0, reg2_data_i};
  assign hilo_cur = {hi_i, lo_i};
  assign cnt_inc  = cnt_q + CNT_W'(1);
  // After any write-back, park in DONE while EX is held so the write is not repeated.
  assign after_wb = ex_stall_i ? S_DONE : S_IDLE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      prod_q    <= '0;
      sub_q     <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      sgn_q     <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      prod_q    <= prod_d;
      sub_q     <= sub_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      sgn_q     <= sgn_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Divider handshake: div_start_o is held high from launch until the cycle
  // div_ready_i is seen; div_annul_o is a one-cycle abort that replaces start.
  always_comb begin
    state_d   = state_q;
    prod_d    = prod_q;
    sub_d     = sub_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    sgn_d     = sgn_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    start_c   = 1'b0;
    annul_c   = 1'b0;
    we_c      = 1'b0;
    stall_c   = 1'b0;
    res_c     = '0;
    if (flush_i) begin
      state_d = S_IDLE;
      annul_c = (state_q == S_DIV_WAIT);
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_madd) begin
            stall_c = 1'b1;
            prod_d  = is_smul ? mul_s : mul_u;
            sub_d   = is_msub;
            state_d = S_ACC;
          end else if (is_div) begin
            if (reg2_data_i != 32'd0) begin
              start_c = 1'b1;
              stall_c = 1'b1;
              op1_d   = reg1_data_i;
              op2_d   = reg2_data_i;
              sgn_d   = (aluop_i == ALU_DIV_OP);
              cnt_d   = '0;
              state_d = S_DIV_WAIT;
            end else begin
              we_c    = 1'b1;
              state_d = after_wb;
            end
          end
        end
        S_ACC: begin
          we_c    = 1'b1;
          res_c   = sub_q ? (hilo_cur - prod_q) : (hilo_cur + prod_q);
          state_d = after_wb;
        end
        S_DIV_WAIT: begin
          if (div_ready_i) begin
            we_c    = 1'b1;
            res_c   = div_result_i;
            state_d = after_wb;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_W'(DIV_TIMEOUT)) begin
              annul_c   = 1'b1;
              timeout_d = 1'b1;
              we_c      = 1'b1;
              state_d   = after_wb;
            end else begin
              start_c = 1'b1;
              stall_c = 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!ex_stall_i) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Combinational outputs are gated by reset so they drop the instant it asserts.
  assign div_start_o  = rst & start_c;
  assign div_annul_o  = rst & annul_c;
  assign hilo_we_o    = rst & we_c;
  assign stallreq_o   = rst & stall_c;
  assign hi_o         = rst ? res_c[63:32] : 32'd0;
  assign lo_o         = rst ? res_c[31:0] : 32'd0;
  assign div_signed_o = sgn_q;
  assign div_op1_o    = op1_q;
  assign div_op2_o    = op2_q;
  assign timeout_o    = timeout_q;
  assign state_o      = state_q;

endmodule
